seg7_scan8: RTL and testbench

- Downstream consumer of the binary-to-BCD converter's packed 32-bit BCD word (two 4-digit values: upper group bcd[31:16], lower group bcd[15:0]).
- Time-multiplexes the 8 digits onto a common-anode 8-digit seven-segment display.
- Takes a tear-free snapshot of the BCD word once per frame and applies per-group leading-zero blanking.
- Flags non-BCD nibbles with a dash.

---
 rtl/seg7_pkg.sv | 33 +++
 rtl/lz_mask4.sv | 27 ++
 rtl/seg7_scan8.sv | 128 ++++++++++++
 tb/tb_seg7_scan8.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and the seven-segment decoder for the
// 8-digit scanned display.
//   SEG_BLANK    : active-low pattern with every segment off
//   SEG_DASH     : active-low pattern showing only segment g (non-BCD nibble)
//   NUM_DIGITS   : digits on the display
//   GROUP_DIGITS : digits per leading-zero blanking group
//   seg7_decode  : nibble -> active-low {g,f,e,d,c,b,a}
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK    = 7'h7F;
  localparam logic [6:0] SEG_DASH     = 7'h3F;
  localparam int         NUM_DIGITS   = 8;
  localparam int         GROUP_DIGITS = 4;

  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
    logic [6:0] pat;
    case (nibble)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/lz_mask4.sv
// lz_mask4: leading-zero blank mask for one 4-digit BCD group.
//   nibbles : input, 16 bits, digit 3 in [15:12] ... digit 0 in [3:0]
//   blank   : output, 4 bits, bit k = 1 when digit k should be blanked
// A digit is blanked when it and every more-significant digit of the
// group are zero. The least-significant digit always stays visible so a
// zero value still shows "0". Non-BCD nibbles are non-zero here, so a
// dash is never hidden.
module lz_mask4
  import seg7_pkg::*;
(
  input  logic [15:0] nibbles,
  output logic [3:0]  blank
);

  logic all_zero;

  always_comb begin
    blank    = '0;
    all_zero = 1'b1;
    // Walk from the most-significant digit down, carrying "all zero so far".
    for (int k = GROUP_DIGITS - 1; k >= 1; k--) begin
      all_zero = all_zero && (nibbles[4*k +: 4] == 4'd0);
      blank[k] = all_zero;
    end
  end

endmodule

// File: rtl/seg7_scan8.sv
// seg7_scan8: time-multiplexed driver for a common-anode 8-digit
// seven-segment display fed from a packed 32-bit BCD word.
//   clk        : input, system clock, rising edge
//   rst_n      : input, asynchronous active-low reset
//   bcd        : input, 32 bits, nibble k drives digit k (digit 0 rightmost)
//   en         : input, scan enable; low blanks the display
//   dp_mask    : input, 8 bits, decimal point per digit, 1 = lit
//   an         : output, 8 bits, digit anodes, active low
//   seg        : output, 7 bits, segments {g,f,e,d,c,b,a}, active low
//   dp         : output, decimal point, active low
//   frame_done : output, one-cycle pulse after digit 7 finishes
// Parameters:
//   SCAN_DIV : clk cycles each digit is lit (2..2^20)
//   LZ_BLANK : 1 = blank leading zeros within each 4-digit group
module seg7_scan8
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bcd,
  input  logic        en,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int          DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0]  IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div, div_next;
  logic [2:0]       idx, idx_next;
  logic [31:0]      snap, snap_next;
  logic             fd_next;
  logic             tick;

  logic [3:0] blank_hi, blank_lo;
  logic [7:0] blank_all;
  logic [3:0] nib;
  logic [6:0] seg_next;
  logic [7:0] an_next;

  // Divider / digit index / snapshot next-state.
  assign tick = (div == DIV_LAST);

  always_comb begin
    div_next  = div;
    idx_next  = idx;
    snap_next = snap;
    fd_next   = 1'b0;
    if (!en) begin
      // Keep re-sampling while disabled so enabling starts on a fresh value.
      div_next  = '0;
      idx_next  = '0;
      snap_next = bcd;
    end else if (tick) begin
      div_next = '0;
      idx_next = idx + 3'd1;
      if (idx == IDX_LAST) begin
        // Frame boundary: the only point bcd is captured while scanning.
        snap_next = bcd;
        fd_next   = 1'b1;
      end
    end else begin
      div_next = div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div  <= '0;
      idx  <= '0;
      snap <= '0;
    end else begin
      div  <= div_next;
      idx  <= idx_next;
      snap <= snap_next;
    end
  end

  // Per-group leading-zero masks computed from the frame snapshot.
  lz_mask4 u_lz_hi (
    .nibbles (snap[31:16]),
    .blank   (blank_hi)
  );

  lz_mask4 u_lz_lo (
    .nibbles (snap[15:0]),
    .blank   (blank_lo)
  );

  assign blank_all = {blank_hi, blank_lo};
  assign nib       = snap[{idx, 2'b00} +: 4];
  assign an_next   = ~(8'd1 << idx);

  always_comb begin
    seg_next = seg7_decode(nib);
    if (LZ_BLANK && blank_all[idx]) begin
      seg_next = SEG_BLANK;
    end
  end

  // Output registers: one cycle behind idx/snap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 8'hFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else if (!en) begin
      an         <= 8'hFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_next;
      seg        <= seg_next;
      dp         <= ~dp_mask[idx];
      frame_done <= fd_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan8.sv
// tb_seg7_scan8: scoreboard bench for seg7_scan8 with SCAN_DIV=4.
// Two instances share the inputs: one with leading-zero blanking, one
// without. A behavioural model queues the expected outputs on every
// rising edge; they are popped and compared on the falling edge.
module tb_seg7_scan8;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] bcd = '0;
  logic        en = 1'b0;
  logic [7:0]  dp_mask = '0;

  logic [7:0] an_lz, an_all;
  logic [6:0] seg_lz, seg_all;
  logic       dp_lz, dp_all, fd_lz, fd_all;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_scan8 #(.SCAN_DIV(SD), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .en(en), .dp_mask(dp_mask),
    .an(an_lz), .seg(seg_lz), .dp(dp_lz), .frame_done(fd_lz)
  );

  seg7_scan8 #(.SCAN_DIV(SD), .LZ_BLANK(1'b0)) dut_all (
    .clk(clk), .rst_n(rst_n), .bcd(bcd), .en(en), .dp_mask(dp_mask),
    .an(an_all), .seg(seg_all), .dp(dp_all), .frame_done(fd_all)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_decode(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg_lz;
    logic [6:0] seg_all;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t q[$];

  int          m_div = 0;
  int          m_idx = 0;
  logic [31:0] m_snap = '0;

  always @(negedge rst_n) begin
    q.delete();
    m_div  = 0;
    m_idx  = 0;
    m_snap = '0;
  end

  always @(posedge clk) begin
    exp_t e;
    logic [3:0] n;
    logic       zero;
    int         top;
    if (!rst_n) begin
      m_div  = 0;
      m_idx  = 0;
      m_snap = '0;
      e = '{an: 8'hFF, seg_lz: 7'h7F, seg_all: 7'h7F, dp: 1'b1, fd: 1'b0};
      q.push_back(e);
    end else if (!en) begin
      e = '{an: 8'hFF, seg_lz: 7'h7F, seg_all: 7'h7F, dp: 1'b1, fd: 1'b0};
      q.push_back(e);
      m_div  = 0;
      m_idx  = 0;
      m_snap = bcd;
    end else begin
      n    = m_snap[m_idx*4 +: 4];
      top  = (m_idx >= 4) ? 7 : 3;
      zero = 1'b1;
      for (int j = m_idx; j <= top; j++)
        if (m_snap[j*4 +: 4] != 4'd0) zero = 1'b0;
      e.an      = ~(8'd1 << m_idx);
      e.seg_all = ref_decode(n);
      e.seg_lz  = (zero && (m_idx % 4 != 0)) ? 7'h7F : ref_decode(n);
      e.dp      = ~dp_mask[m_idx];
      e.fd      = (m_div == SD - 1) && (m_idx == 7);
      q.push_back(e);
      if (m_div == SD - 1) begin
        m_div = 0;
        if (m_idx == 7) m_snap = bcd;
        m_idx = (m_idx + 1) % 8;
      end else begin
        m_div = m_div + 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check_val("an_lz",  {24'd0, an_lz},  {24'd0, e.an});
      check_val("seg_lz", {25'd0, seg_lz}, {25'd0, e.seg_lz});
      check_val("dp_lz",  {31'd0, dp_lz},  {31'd0, e.dp});
      check_val("fd_lz",  {31'd0, fd_lz},  {31'd0, e.fd});
      check_val("an_all",  {24'd0, an_all},  {24'd0, e.an});
      check_val("seg_all", {25'd0, seg_all}, {25'd0, e.seg_all});
      check_val("dp_all",  {31'd0, dp_all},  {31'd0, e.dp});
      check_val("fd_all",  {31'd0, fd_all},  {31'd0, e.fd});
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Wait for the model to reach a given index (and divider, unless div<0).
  task automatic wait_pos(input string tag, input int idx, input int div, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk);
      #1;
      if (m_idx == idx && (div < 0 || m_div == div)) found = 1'b1;
    end
    if (!found) check_val(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then load the first value while disabled.
    rst_n = 1'b0; en = 1'b0; bcd = 32'h0123_0045; dp_mask = 8'h00;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    en = 1'b1;
    cycles(70);

    // Decimal points follow dp_mask live.
    dp_mask = 8'hA5;
    cycles(36);
    dp_mask = 8'h00;

    // Mid-frame bcd change is deferred to the next frame.
    bcd = 32'h1111_1111;
    cycles(40);
    wait_pos("wait_idx3", 3, -1, 64);
    @(negedge clk);
    bcd = 32'h2222_2222;
    cycles(70);

    // Dash in digit 0, upper group all zero.
    bcd = 32'h0000_000A;
    cycles(70);
    bcd = 32'hF030_0B00;
    cycles(70);

    // Disable for 10 cycles; last disabled cycle sets the snapshot.
    en = 1'b0;
    cycles(5);
    bcd = 32'h0987_6543;
    cycles(4);
    bcd = 32'h1000_0002;
    cycles(1);
    en = 1'b1;
    bcd = 32'h5555_5555;
    cycles(40);

    // Asynchronous reset in the middle of a frame.
    wait_pos("wait_idx5_div2", 5, 2, 64);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_an",  {24'd0, an_lz},  32'hFF);
    check_val("async_rst_seg", {25'd0, seg_lz}, 32'h7F);
    check_val("async_rst_dp",  {31'd0, dp_lz},  32'h1);
    check_val("async_rst_fd",  {31'd0, fd_lz},  32'h0);
    check_val("async_rst_an_all", {24'd0, an_all}, 32'hFF);
    cycles(3);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("resume_an", {24'd0, an_lz}, 32'hFE);
    cycles(40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
